// File: rtl/part_trgt_pkg.sv
// Shared definitions for the mission-clock target sequencer.
// Holds the sequencer FSM state encoding and the default parameter values
// used by part_trgt_seq and its round-robin selector.
package part_trgt_pkg;

  localparam int N_CH_DEF   = 4;
  localparam int DW_DEF     = 8;
  localparam int WD_MAX_DEF = 10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_RECV  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

endpackage

// File: rtl/part_trgt_rr_arb.sv
// Round-robin channel selector (purely combinational).
// Searches the pending vector starting at (last_i + 1) mod N_CH and returns
// the first pending channel found.
// Ports:
//   pending_i  per-channel request bits
//   last_i     index of the most recently serviced channel
//   grant_o    one-hot grant of the selected channel
//   idx_o      index of the selected channel
//   valid_o    at least one channel is pending
module part_trgt_rr_arb
  import part_trgt_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  localparam int CW  = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] pending_i,
  input  logic [CW-1:0]   last_i,
  output logic [N_CH-1:0] grant_o,
  output logic [CW-1:0]   idx_o,
  output logic            valid_o
);

  logic          found;
  logic [CW:0]   sum;
  logic [CW-1:0] cand;

  // The sum is one bit wider than an index so last_i + i (at most 2*N_CH-1)
  // never overflows before the manual modulo wrap.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int i = 1; i <= N_CH; i++) begin
      sum = {1'b0, last_i} + (CW+1)'(i);
      if (sum >= (CW+1)'(N_CH)) begin
        sum = sum - (CW+1)'(N_CH);
      end
      cand = sum[CW-1:0];
      if (!found && pending_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/part_trgt_seq.sv
// Mission-clock target sequencer.
// Detects rising edges on per-channel mission clocks, freezes the channel,
// and services channels round-robin: optionally sends a vector out (SEND),
// optionally receives a data word back (RECV), then releases the freeze.
// A watchdog traps stalled transactions in ERROR until reset.
// Ports:
//   clk_i, rst_i          utility clock, synchronous active-high reset
//   mclk_i                mission clock levels (sampled on clk_i)
//   put_en_i, get_en_i    enable the send / receive phases
//   sut_i                 {valid, data} from the SUT, sent for channel N_CH-1
//   tx_*                  outgoing vector stream
//   rx_*                  incoming data stream
//   freeze_o              per-channel mission clock hold
//   chan_data_o           last received {wen, data} per channel
//   busy_o                FSM not idle
//   wd_err_o, ovr_o, ch_err_o  sticky error flags
//   dbg_state_o           current FSM state, for observation only
//
// Handshakes: a word transfers on a clk_i edge where valid and ready are both
// 1. tx_valid_o, tx_ch_o and tx_data_o are held stable until tx_ready_i; a
// receive word is consumed only when rx_ready_o is 1 (words arriving while
// rx_ready_o is 0 are ignored).
module part_trgt_seq
  import part_trgt_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DW     = DW_DEF,
  parameter int WD_MAX = WD_MAX_DEF,
  localparam int CW    = $clog2(N_CH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_CH-1:0]        mclk_i,
  input  logic                   put_en_i,
  input  logic                   get_en_i,
  input  logic [DW:0]            sut_i,
  output logic                   tx_valid_o,
  output logic [CW-1:0]          tx_ch_o,
  output logic [DW:0]            tx_data_o,
  input  logic                   tx_ready_i,
  input  logic                   rx_valid_i,
  input  logic [CW-1:0]          rx_ch_i,
  input  logic [DW:0]            rx_data_i,
  output logic                   rx_ready_o,
  output logic [N_CH-1:0]        freeze_o,
  output logic [N_CH*(DW+1)-1:0] chan_data_o,
  output logic                   busy_o,
  output logic                   wd_err_o,
  output logic                   ovr_o,
  output logic                   ch_err_o,
  output state_t                 dbg_state_o
);

  localparam int WDW = $clog2(WD_MAX + 1);

  state_t            state_q, state_d;
  logic [N_CH-1:0]   mclk_q;
  logic [N_CH-1:0]   armed_q;
  logic [N_CH-1:0]   pending_q;
  logic [N_CH-1:0]   edge_det;
  logic [N_CH-1:0]   cpl_mask;
  logic [CW-1:0]     sel_q;
  logic [CW-1:0]     last_q;
  logic [DW:0]       tx_data_q;
  logic [WDW-1:0]    wd_q;
  logic [DW:0]       chan_q [N_CH];
  logic              wd_err_q, ovr_q, ch_err_q;

  logic [N_CH-1:0]   arb_grant;
  logic [CW-1:0]     arb_idx;
  logic              arb_valid;

  logic              ld_sel, cpl_en, wd_clr, wd_inc, wr_en;
  logic              ch_err_set, wd_err_set, wd_hit;
  logic [CW-1:0]     cpl_idx;

  part_trgt_rr_arb #(.N_CH(N_CH)) u_arb (
    .pending_i (pending_q),
    .last_i    (last_q),
    .grant_o   (arb_grant),
    .idx_o     (arb_idx),
    .valid_o   (arb_valid)
  );

  // armed_q blocks a channel until it has been seen low after reset, so a
  // clock that is already high when reset releases does not fake an edge.
  assign edge_det = mclk_i & ~mclk_q & armed_q;

  always_comb begin
    state_d    = state_q;
    ld_sel     = 1'b0;
    cpl_en     = 1'b0;
    cpl_idx    = sel_q;
    wd_clr     = 1'b0;
    wd_inc     = 1'b0;
    wr_en      = 1'b0;
    ch_err_set = 1'b0;
    wd_err_set = 1'b0;
    wd_hit     = (wd_q == WDW'(WD_MAX - 1));
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          ld_sel  = 1'b1;
          cpl_idx = arb_idx;
          if (put_en_i) begin
            state_d = ST_SEND;
            wd_clr  = 1'b1;
          end else if (get_en_i) begin
            state_d = ST_RECV;
            wd_clr  = 1'b1;
          end else begin
            cpl_en = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (tx_ready_i) begin
          if (get_en_i) begin
            state_d = ST_RECV;
            wd_clr  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cpl_en  = 1'b1;
          end
        end else if (wd_hit) begin
          state_d    = ST_ERROR;
          wd_err_set = 1'b1;
        end else begin
          wd_inc = 1'b1;
        end
      end
      ST_RECV: begin
        if (rx_valid_i && (rx_ch_i == sel_q)) begin
          state_d = ST_IDLE;
          wr_en   = 1'b1;
          cpl_en  = 1'b1;
        end else begin
          ch_err_set = rx_valid_i;
          if (wd_hit) begin
            state_d    = ST_ERROR;
            wd_err_set = 1'b1;
          end else begin
            wd_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_ERROR;
    endcase
  end

  // In IDLE the completing channel is the arbiter's pick; otherwise it is the
  // channel latched when the transaction started.
  always_comb begin
    cpl_mask = '0;
    if (cpl_en) begin
      cpl_mask = (state_q == ST_IDLE) ? arb_grant : (N_CH'(1) << sel_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mclk_q    <= '0;
      armed_q   <= '0;
      pending_q <= '0;
      sel_q     <= '0;
      last_q    <= CW'(N_CH - 1);
      tx_data_q <= '0;
      wd_q      <= '0;
      wd_err_q  <= 1'b0;
      ovr_q     <= 1'b0;
      ch_err_q  <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        chan_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mclk_q    <= mclk_i;
      armed_q   <= armed_q | ~mclk_i;
      // A new edge on a completing channel re-arms it rather than overrunning.
      pending_q <= (pending_q & ~cpl_mask) | edge_det;
      if (|(edge_det & pending_q & ~cpl_mask)) begin
        ovr_q <= 1'b1;
      end
      if (ch_err_set) begin
        ch_err_q <= 1'b1;
      end
      if (wd_err_set) begin
        wd_err_q <= 1'b1;
      end
      if (ld_sel) begin
        sel_q     <= arb_idx;
        tx_data_q <= (arb_idx == CW'(N_CH - 1)) ? sut_i : '0;
      end
      if (cpl_en) begin
        last_q <= cpl_idx;
      end
      if (wd_clr) begin
        wd_q <= '0;
      end else if (wd_inc) begin
        wd_q <= wd_q + WDW'(1);
      end
      if (wr_en) begin
        chan_q[sel_q] <= rx_data_i;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    assign chan_data_o[k*(DW+1) +: DW+1] = chan_q[k];
  end

  assign tx_valid_o  = (state_q == ST_SEND);
  assign tx_ch_o     = sel_q;
  assign tx_data_o   = tx_data_q;
  assign rx_ready_o  = (state_q == ST_RECV);
  assign freeze_o    = pending_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign wd_err_o    = wd_err_q;
  assign ovr_o       = ovr_q;
  assign ch_err_o    = ch_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_part_trgt_seq.sv
// Testbench for part_trgt_seq: directed scenarios plus randomized rounds of
// simultaneous mission clock edges checked against a transaction-level model.
module tb_part_trgt_seq;
  import part_trgt_pkg::*;

  localparam int N_CH   = 4;
  localparam int DW     = 8;
  localparam int WD_MAX = 16;
  localparam int CW     = 2;
  localparam int WW     = DW + 1;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic [N_CH-1:0]      mclk_i = '0;
  logic                 put_en_i = 1'b0;
  logic                 get_en_i = 1'b0;
  logic [WW-1:0]        sut_i = '0;
  logic                 tx_valid_o;
  logic [CW-1:0]        tx_ch_o;
  logic [WW-1:0]        tx_data_o;
  logic                 tx_ready_i = 1'b0;
  logic                 rx_valid_i = 1'b0;
  logic [CW-1:0]        rx_ch_i = '0;
  logic [WW-1:0]        rx_data_i = '0;
  logic                 rx_ready_o;
  logic [N_CH-1:0]      freeze_o;
  logic [N_CH*WW-1:0]   chan_data_o;
  logic                 busy_o, wd_err_o, ovr_o, ch_err_o;
  state_t               dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: received words per channel, pending set, last serviced.
  logic [WW-1:0]   chan_m [N_CH];
  logic [N_CH-1:0] pend_m;
  int              last_m;
  logic [CW-1:0]   exp_q [$];

  part_trgt_seq #(.N_CH(N_CH), .DW(DW), .WD_MAX(WD_MAX)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .mclk_i      (mclk_i),
    .put_en_i    (put_en_i),
    .get_en_i    (get_en_i),
    .sut_i       (sut_i),
    .tx_valid_o  (tx_valid_o),
    .tx_ch_o     (tx_ch_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ch_i     (rx_ch_i),
    .rx_data_i   (rx_data_i),
    .rx_ready_o  (rx_ready_o),
    .freeze_o    (freeze_o),
    .chan_data_o (chan_data_o),
    .busy_o      (busy_o),
    .wd_err_o    (wd_err_o),
    .ovr_o       (ovr_o),
    .ch_err_o    (ch_err_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=hang exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) chan_m[k] = '0;
    pend_m = '0;
    last_m = N_CH - 1;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    rst_i      = 1'b1;
    tx_ready_i = 1'b0;
    rx_valid_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b0;
    model_reset();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N_CH*WW-1:0] chan_exp();
    logic [N_CH*WW-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k*WW +: WW] = chan_m[k];
    return v;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_tx_valid"}, tx_valid_o, 0);
    check({tag, "_rx_ready"}, rx_ready_o, 0);
    check({tag, "_busy"},     busy_o, 0);
    check({tag, "_freeze"},   freeze_o, 0);
    check({tag, "_chan"},     chan_data_o, 0);
    check({tag, "_wd_err"},   wd_err_o, 0);
    check({tag, "_ovr"},      ovr_o, 0);
    check({tag, "_ch_err"},   ch_err_o, 0);
    check({tag, "_state"},    dbg_state, ST_IDLE);
  endtask

  // Round-robin service order for everything pending: scan upward from the
  // channel after the last one serviced, wrapping around.
  task automatic plan_services(input logic [N_CH-1:0] mask);
    pend_m = pend_m | mask;
    while (pend_m != 0) begin
      for (int i = 1; i <= N_CH; i++) begin
        int c;
        c = (last_m + i) % N_CH;
        if (pend_m[c]) begin
          exp_q.push_back(CW'(c));
          pend_m[c] = 1'b0;
          last_m    = c;
          break;
        end
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic raise(input logic [N_CH-1:0] mask);
    mclk_i = mclk_i | mask;
  endtask

  task automatic lower(input logic [N_CH-1:0] mask);
    mclk_i = mclk_i & ~mask;
  endtask

  task automatic pulse(input logic [N_CH-1:0] mask);
    raise(mask);
    tick();
    lower(mask);
    tick();
  endtask

  task automatic do_tx(input int ch, input int delay);
    logic [WW-1:0] exp_d;
    int w;
    exp_d = (ch == N_CH - 1) ? sut_i : '0;
    w = 0;
    while (!tx_valid_o && w < 20) begin
      tick();
      w++;
    end
    check("tx_valid", tx_valid_o, 1);
    check("tx_ch", tx_ch_o, ch);
    check("tx_data", tx_data_o, exp_d);
    sut_i = WW'($urandom_range(0, 511));
    for (int d = 0; d < delay; d++) begin
      tick();
      check("tx_hold_valid", tx_valid_o, 1);
      check("tx_hold_ch", tx_ch_o, ch);
      check("tx_hold_data", tx_data_o, exp_d);
    end
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
  endtask

  task automatic do_rx(input int ch, input logic [WW-1:0] data, input int delay);
    int w;
    w = 0;
    while (!rx_ready_o && w < 20) begin
      tick();
      w++;
    end
    check("rx_ready", rx_ready_o, 1);
    repeat (delay) tick();
    rx_valid_i = 1'b1;
    rx_ch_i    = CW'(ch);
    rx_data_i  = data;
    tick();
    rx_valid_i = 1'b0;
    chan_m[ch] = data;
    check("chan_data", chan_data_o, chan_exp());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic [N_CH-1:0] mask;
    logic pe, ge;

    model_reset();
    apply_reset();
    check_reset_state("reset");

    // A clock already high at reset release must not count as an edge.
    mclk_i = 4'b0010;
    apply_reset();
    repeat (3) tick();
    check("hi_at_reset_freeze", freeze_o, 4'b0000);
    lower(4'b0010);
    tick();
    raise(4'b0010);
    tick();
    check("first_edge_freeze", freeze_o, 4'b0010);
    lower(4'b0010);
    tick();
    check("no_put_no_get_freeze", freeze_o, 4'b0000);
    check("no_put_no_get_busy", busy_o, 0);
    last_m = 1;

    // Receive-only service of ch1, word arriving a few cycles late.
    put_en_i = 1'b0;
    get_en_i = 1'b1;
    raise(4'b0010);
    tick();
    check("rx1_freeze_set", freeze_o, 4'b0010);
    lower(4'b0010);
    tick();
    check("rx1_in_recv", rx_ready_o, 1);
    tick();
    tick();
    check("rx1_freeze_hold", freeze_o, 4'b0010);
    rx_valid_i = 1'b1;
    rx_ch_i    = 2'd1;
    rx_data_i  = 9'h1A5;
    tick();
    rx_valid_i = 1'b0;
    chan_m[1]  = 9'h1A5;
    check("rx1_freeze_clr", freeze_o, 4'b0000);
    check("rx1_chan", chan_data_o, chan_exp());
    last_m = 1;

    // Send then receive on ch3 with a slow tx_ready.
    put_en_i = 1'b1;
    get_en_i = 1'b1;
    sut_i    = 9'h155;
    pulse(4'b1000);
    do_tx(3, 5);
    check("tx3_recv_next", rx_ready_o, 1);
    check("tx3_valid_drop", tx_valid_o, 0);
    do_rx(3, WW'($urandom_range(0, 511)), 1);
    last_m = 3;

    // Round robin: after ch0, simultaneous ch0+ch2 serves ch2 first.
    put_en_i = 1'b0;
    get_en_i = 1'b1;
    pulse(4'b0001);
    do_rx(0, WW'($urandom_range(0, 511)), 0);
    put_en_i = 1'b1;
    pulse(4'b0101);
    check("rr_freeze_both", freeze_o, 4'b0101);
    do_tx(2, 1);
    do_rx(2, WW'($urandom_range(0, 511)), 0);
    do_tx(0, 0);
    do_rx(0, WW'($urandom_range(0, 511)), 0);
    last_m = 0;

    // Overrun on a pending channel, then a wrong-channel word.
    put_en_i = 1'b0;
    get_en_i = 1'b1;
    pulse(4'b0010);
    check("ovr_before", ovr_o, 0);
    raise(4'b0010);
    tick();
    check("ovr_set", ovr_o, 1);
    lower(4'b0010);
    tick();
    rx_valid_i = 1'b1;
    rx_ch_i    = 2'd2;
    rx_data_i  = 9'h0FF;
    tick();
    rx_valid_i = 1'b0;
    check("ch_err_set", ch_err_o, 1);
    check("ch_err_chan_kept", chan_data_o, chan_exp());
    check("ch_err_still_recv", rx_ready_o, 1);
    do_rx(1, 9'h033, 0);
    repeat (3) tick();
    check("ovr_single_busy", busy_o, 0);
    check("ovr_single_freeze", freeze_o, 4'b0000);

    // Watchdog: receive never arrives.
    apply_reset();
    tick();
    put_en_i = 1'b0;
    get_en_i = 1'b1;
    pulse(4'b0001);
    cnt = 0;
    while (rx_ready_o && cnt < 40) begin
      cnt++;
      tick();
    end
    check("wd_recv_cycles", cnt, WD_MAX);
    check("wd_err", wd_err_o, 1);
    check("wd_state", dbg_state, ST_ERROR);
    check("wd_busy", busy_o, 1);
    check("wd_rx_ready", rx_ready_o, 0);
    check("wd_tx_valid", tx_valid_o, 0);
    check("wd_freeze", freeze_o, 4'b0001);
    pulse(4'b0100);
    check("wd_freeze_new_edge", freeze_o, 4'b0101);
    rx_valid_i = 1'b1;
    rx_ch_i    = 2'd0;
    rx_data_i  = 9'h111;
    tick();
    rx_valid_i = 1'b0;
    check("wd_chan_kept", chan_data_o, 0);
    check("wd_still_error", dbg_state, ST_ERROR);
    apply_reset();
    check_reset_state("wd_reset");
    tick();

    // Randomized rounds against the model.
    for (int r = 0; r < 30; r++) begin
      pe   = 1'($urandom_range(0, 1));
      ge   = 1'($urandom_range(0, 1));
      put_en_i = pe;
      get_en_i = ge;
      sut_i    = WW'($urandom_range(0, 511));
      mask     = N_CH'($urandom_range(1, 15));
      plan_services(mask);
      pulse(mask);
      while (exp_q.size() > 0) begin
        logic [CW-1:0] ch;
        ch = exp_q.pop_front();
        if (pe) do_tx(int'(ch), $urandom_range(0, 4));
        if (ge) do_rx(int'(ch), WW'($urandom_range(0, 511)), $urandom_range(0, 3));
      end
      repeat (4) tick();
      check("rand_freeze", freeze_o, 0);
      check("rand_busy", busy_o, 0);
      check("rand_chan", chan_data_o, chan_exp());
    end
    check("rand_ovr", ovr_o, 0);
    check("rand_ch_err", ch_err_o, 0);
    check("rand_wd_err", wd_err_o, 0);

    // Reset in the middle of SEND abandons the transaction.
    put_en_i = 1'b1;
    get_en_i = 1'b1;
    pulse(4'b1000);
    check("mid_send_valid", tx_valid_o, 1);
    rst_i = 1'b1;
    tick();
    check_reset_state("mid_send_reset");
    rst_i = 1'b0;
    model_reset();
    repeat (3) tick();
    check("after_reset_no_tx", tx_valid_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
